sr_btn_driver: RTL and testbench

- Upstream command stage for the SR flip-flop (ports s, r, clk, rst, q).
- Takes two raw, asynchronous push-button inputs (set and clear), synchronises and debounces them, and converts each debounced press into a clean, registered, fixed-width s or r pulse.
- Guarantees s and r are never both high, which is the forbidden input for the SR flip-flop.
- Reports conflicting and dropped requests.

---
 rtl/sr_btn_driver.sv | 201 ++++++++++++++++++++
 tb/tb_sr_btn_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_btn_driver.sv
// sr_btn_driver
//
// Command stage that sits in front of an SR flip-flop. Two raw push buttons
// (set and clear) are synchronised, debounced and edge-detected. Each accepted
// press becomes a clean, fixed-width, registered pulse on s or r. The two
// outputs are never high together, because that is the forbidden input of the
// SR flip-flop downstream.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset
//   set_btn  in   raw set button (asynchronous, may bounce)
//   clr_btn  in   raw clear button (asynchronous, may bounce)
//   s        out  registered set pulse, PULSE_W cycles per accepted press
//   r        out  registered reset pulse, PULSE_W cycles per accepted press
//   busy     out  high while a pulse or the trailing guard gap is in progress
//   conflict out  one-cycle flag: set and clear accepted in the same idle cycle
//   drop     out  one-cycle flag: a press was accepted while busy and discarded
//
// Parameters:
//   DB_CYCLES  consecutive stable synchronised cycles needed to accept a change
//   CNT_W      debounce counter width, 2**CNT_W must exceed DB_CYCLES
//   PULSE_W    length of each s or r pulse in cycles

module sr_btn_driver #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int PULSE_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic drop
);

  localparam int PC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PULSE_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE_S,
    DRIVE_R,
    GAP
  } state_t;

  // Channel 0 is the set button, channel 1 is the clear button.
  logic [1:0]       btnRaw;
  logic [1:0]       meta_q;
  logic [1:0]       sync_q;
  logic [1:0]       dbLevel_q;
  logic [1:0]       dbLevel_d;
  logic [1:0]       dbDly_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       ev;
  logic             setEv;
  logic             clrEv;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic             sOut_q;
  logic             rOut_q;
  logic             busy_q;
  logic             conflict_q;
  logic             drop_q;

  assign btnRaw = {clr_btn, set_btn};

  // Two-flop synchroniser per button. The buttons are asynchronous to clk, so
  // nothing downstream looks at them before the second flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btnRaw;
      sync_q <= meta_q;
    end
  end

  // Debounce next-state. The counter only advances while the synchronised
  // level disagrees with the accepted level, and any agreement clears it, so a
  // glitch shorter than DB_CYCLES cycles never reaches the debounced level.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      dbLevel_d[ch] = dbLevel_q[ch];
      cnt_d[ch]     = cnt_q[ch];
      if (sync_q[ch] == dbLevel_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        dbLevel_d[ch] = sync_q[ch];
        cnt_d[ch]     = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Debounce state plus a delayed copy of the debounced level, used to turn a
  // rising debounced level into a single-cycle press event.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbLevel_q <= '0;
      dbDly_q   <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      dbLevel_q <= dbLevel_d;
      dbDly_q   <= dbLevel_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  // Only presses produce events; releases are ignored.
  assign ev    = dbLevel_q & ~dbDly_q;
  assign setEv = ev[0];
  assign clrEv = ev[1];

  // Pulse sequencer. Every output is registered and written together with the
  // state it belongs to, so s and r are a pure function of the stored state
  // and can never be high in the same cycle. A one-cycle GAP follows every
  // pulse so back-to-back presses cannot produce adjacent s/r pulses. Events
  // that arrive outside IDLE, including during GAP, are discarded and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      sOut_q     <= 1'b0;
      rOut_q     <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          pc_q <= '0;
          if (setEv && !clrEv) begin
            state_q <= DRIVE_S;
            sOut_q  <= 1'b1;
            rOut_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (clrEv && !setEv) begin
            state_q <= DRIVE_R;
            sOut_q  <= 1'b0;
            rOut_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q    <= IDLE;
            sOut_q     <= 1'b0;
            rOut_q     <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= setEv & clrEv;
          end
        end
        DRIVE_S, DRIVE_R: begin
          drop_q <= setEv | clrEv;
          if (pc_q == PC_LAST) begin
            state_q <= GAP;
            pc_q    <= '0;
            sOut_q  <= 1'b0;
            rOut_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        GAP: begin
          drop_q  <= setEv | clrEv;
          state_q <= IDLE;
          pc_q    <= '0;
          sOut_q  <= 1'b0;
          rOut_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          pc_q    <= '0;
          sOut_q  <= 1'b0;
          rOut_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s        = sOut_q;
  assign r        = rOut_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_sr_btn_driver.sv
// tb_sr_btn_driver
//
// Directed bench for sr_btn_driver (DB_CYCLES=4, PULSE_W=2). A reference model
// predicts every output from the press/release timing rules: a button sample
// becomes visible two edges after it is taken, a level is accepted once it has
// disagreed with the accepted level on DB_CYCLES consecutive edges, and an
// accepted press occupies a window of PULSE_W drive edges plus one gap edge.
// Hand-computed edge numbers and pulse counts pin the model itself.

module tb_sr_btn_driver;

  localparam int DB   = 4;
  localparam int PW   = 2;
  localparam int HIST = 1024;

  logic clk;
  logic rst;
  logic set_btn;
  logic clr_btn;
  logic s;
  logic r;
  logic busy;
  logic conflict;
  logic drop;

  sr_btn_driver #(
    .DB_CYCLES(DB),
    .CNT_W(3),
    .PULSE_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_btn(set_btn),
    .clr_btn(clr_btn),
    .s(s),
    .r(r),
    .busy(busy),
    .conflict(conflict),
    .drop(drop)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Edge-indexed history used by the reference model.
  int edgeCnt = 0;
  bit effS [HIST];
  bit effC [HIST];
  bit rstH [HIST];
  bit dbS  [HIST];
  bit dbC  [HIST];

  bit modelValid = 1'b0;
  int busyEnd    = -100;
  int pulseStart = -100;
  bit pulseIsSet = 1'b0;
  bit expS, expR, expBusy, expConf, expDrop;
  bit mEvS, mEvR, mActive;
  int mE;

  // Monitors built from DUT outputs, for the literal checks.
  bit prevS = 1'b0;
  bit prevR = 1'b0;
  int sRiseEdge = -1;
  int sRiseCount = 0;
  int rRiseCount = 0;
  int sHighCount = 0;
  int busyCount = 0;
  int conflictCount = 0;
  int dropCount = 0;
  bit qFf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  task automatic applyStimulus(input bit setV, input bit clrV, input bit rstV, input int cycles);
    set_btn = setV;
    clr_btn = clrV;
    rst     = rstV;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Synchronised level seen at edge e: the sample taken two edges earlier,
  // or zero if the synchroniser was cleared in between.
  function automatic bit sbAt(input bit isSet, input int e);
    if (e < 2) return 1'b0;
    if (rstH[e-1]) return 1'b0;
    return isSet ? effS[e-2] : effC[e-2];
  endfunction

  // Accepted level after edge e: flips only when the last DB edges were all
  // out of reset and all disagreed with the previously accepted level.
  function automatic bit dbNext(input bit isSet, input int e, input bit prevDb);
    for (int j = 0; j < DB; j++) begin
      if (e - j < 1) return prevDb;
      if (rstH[e-j]) return prevDb;
      if (sbAt(isSet, e - j) == prevDb) return prevDb;
    end
    return ~prevDb;
  endfunction

  // Reference model, advanced once per rising edge with the inputs that edge
  // samples. A started pulse owns edges pulseStart..pulseStart+PW for busy and
  // pulseStart..pulseStart+PW-1 for s or r.
  always @(posedge clk) begin
    edgeCnt++;
    mE = edgeCnt;
    if (mE < HIST) begin
      rstH[mE] = rst;
      effS[mE] = rst ? 1'b0 : set_btn;
      effC[mE] = rst ? 1'b0 : clr_btn;
      if (rst) begin
        dbS[mE]    = 1'b0;
        dbC[mE]    = 1'b0;
        busyEnd    = -100;
        pulseStart = -100;
        expS       = 1'b0;
        expR       = 1'b0;
        expBusy    = 1'b0;
        expConf    = 1'b0;
        expDrop    = 1'b0;
        modelValid = 1'b1;
      end else begin
        dbS[mE] = dbNext(1'b1, mE, dbS[mE-1]);
        dbC[mE] = dbNext(1'b0, mE, dbC[mE-1]);
        mEvS    = (mE >= 3) && dbS[mE-1] && !dbS[mE-2];
        mEvR    = (mE >= 3) && dbC[mE-1] && !dbC[mE-2];
        mActive = (busyEnd >= mE - 1);
        expDrop = mActive && (mEvS || mEvR);
        expConf = !mActive && mEvS && mEvR;
        if (!mActive && (mEvS != mEvR)) begin
          pulseStart = mE;
          pulseIsSet = mEvS;
          busyEnd    = mE + PW;
        end
        expS    = pulseIsSet  && (mE >= pulseStart) && (mE <= pulseStart + PW - 1);
        expR    = !pulseIsSet && (mE >= pulseStart) && (mE <= pulseStart + PW - 1);
        expBusy = (mE >= pulseStart) && (mE <= busyEnd);
      end
    end
  end

  // Behavioural SR flip-flop fed by the driver, standing in for the real
  // downstream consumer.
  always @(posedge clk) begin
    if (rst) qFf <= 1'b0;
    else if (s) qFf <= 1'b1;
    else if (r) qFf <= 1'b0;
  end

  // Compare process on the falling edge, away from the sampling edge, plus
  // the pulse monitors used by the directed checks.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("s", s, expS);
      checkOutput("r", r, expR);
      checkOutput("busy", busy, expBusy);
      checkOutput("conflict", conflict, expConf);
      checkOutput("drop", drop, expDrop);
      checkOutput("s_and_r", s & r, 0);
      if (s && !prevS) begin
        sRiseEdge = edgeCnt;
        sRiseCount++;
      end
      if (r && !prevR) rRiseCount++;
      if (s) sHighCount++;
      if (busy) busyCount++;
      if (conflict) conflictCount++;
      if (drop) dropCount++;
      prevS = s;
      prevR = r;
    end
  end

  // Directed sequence. Each phase records monitor counts first and checks the
  // differences afterwards against hand-computed values.
  initial begin
    int pressEdge, sBase, rBase, hBase, bBase, cBase, dBase;
    set_btn = 1'b0;
    clr_btn = 1'b0;
    rst     = 1'b1;

    $display("[TB] Phase 1: reset with both buttons held");
    applyStimulus(1'b1, 1'b1, 1'b1, 2);
    checkOutput("t1_reset_s", s, 0);
    checkOutput("t1_reset_busy", busy, 0);
    sBase = sRiseCount; rBase = rRiseCount;
    pressEdge = edgeCnt + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    checkOutput("t1_s_rise_edge", sRiseEdge, pressEdge + 6);
    checkOutput("t1_s_pulses", sRiseCount - sBase, 1);
    checkOutput("t1_r_pulses", rRiseCount - rBase, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    $display("[TB] Phase 2: clean set press");
    sBase = sRiseCount; rBase = rRiseCount; hBase = sHighCount; bBase = busyCount;
    pressEdge = edgeCnt + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    checkOutput("t2_s_rise_edge", sRiseEdge, pressEdge + 6);
    checkOutput("t2_s_high_cycles", sHighCount - hBase, 2);
    checkOutput("t2_busy_cycles", busyCount - bBase, 3);
    checkOutput("t2_r_pulses", rRiseCount - rBase, 0);
    checkOutput("t2_q", qFf, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    $display("[TB] Phase 3: bouncing set button");
    sBase = sRiseCount;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2) == 0, 1'b0, 1'b0, 1);
    pressEdge = edgeCnt + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 14);
    checkOutput("t3_s_pulses", sRiseCount - sBase, 1);
    checkOutput("t3_s_rise_edge", sRiseEdge, pressEdge + 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    $display("[TB] Phase 4: simultaneous presses");
    sBase = sRiseCount; rBase = rRiseCount; bBase = busyCount; cBase = conflictCount;
    applyStimulus(1'b1, 1'b1, 1'b0, 14);
    checkOutput("t4_conflict_cycles", conflictCount - cBase, 1);
    checkOutput("t4_s_pulses", sRiseCount - sBase, 0);
    checkOutput("t4_r_pulses", rRiseCount - rBase, 0);
    checkOutput("t4_busy_cycles", busyCount - bBase, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    $display("[TB] Phase 5: clear press while driving s");
    sBase = sRiseCount; rBase = rRiseCount; hBase = sHighCount; dBase = dropCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14);
    checkOutput("t5_drop_cycles", dropCount - dBase, 1);
    checkOutput("t5_r_pulses", rRiseCount - rBase, 0);
    checkOutput("t5_s_pulses", sRiseCount - sBase, 1);
    checkOutput("t5_s_high_cycles", sHighCount - hBase, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);

    $display("[TB] Phase 6: reset during s pulse");
    sBase = sRiseCount; hBase = sHighCount; bBase = busyCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkOutput("t6_s_before_reset", s, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("t6_s_after_reset", s, 0);
    checkOutput("t6_busy_after_reset", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);
    checkOutput("t6_s_pulses", sRiseCount - sBase, 1);
    checkOutput("t6_s_high_cycles", sHighCount - hBase, 1);
    checkOutput("t6_busy_cycles", busyCount - bBase, 1);

    $display("[TB] Phase 7: clear press");
    rBase = rRiseCount;
    applyStimulus(1'b0, 1'b1, 1'b0, 14);
    checkOutput("t7_r_pulses", rRiseCount - rBase, 1);
    checkOutput("t7_q", qFf, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
